// File: rtl/ram_write_arbiter.sv
`timescale 1ns/1ps
// ram_write_arbiter: shares one RAM write port between two valid/ready writers
// using round-robin arbitration. Every accepted write reaches the RAM one cycle
// after its handshake.
// Optional feature macro: RAM_ARB_CLEAR_EN. When it is defined, the whole RAM is
// swept to CLEAR_VALUE after each reset before either writer is accepted.
module ram_write_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 64,
    parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic [DATA_WIDTH-1:0] ram_wrdata,
    output logic                  busy
);

    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

    state_t                state;
    logic                  prio;
    logic                  grant_valid;
    logic                  grant_idx;
    logic [ADDR_WIDTH-1:0] grant_addr;
    logic [DATA_WIDTH-1:0] grant_data;

`ifdef RAM_ARB_CLEAR_EN
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_t                state_next;
    logic [ADDR_WIDTH-1:0] clear_cnt;

    // State register: every reset starts a fresh sweep
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= CLEAR;
        end else begin
            state <= state_next;
        end
    end

    // Leave CLEAR on the edge that issues the last address; RUN is terminal
    always_comb begin
        state_next = state;
        if (state == CLEAR && clear_cnt == LAST_ADDR) begin
            state_next = RUN;
        end
    end

    // Sweep address counter; it parks on the last address so it never starts a second pass
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            clear_cnt <= '0;
        end else if (state == CLEAR && clear_cnt != LAST_ADDR) begin
            clear_cnt <= clear_cnt + ADDR_WIDTH'(1);
        end
    end

    assign busy = (state == CLEAR);
`else
    // Without the sweep the arbiter is permanently in RUN and CLEAR_VALUE has no consumer
    logic unused_clear_value;

    assign state              = RUN;
    assign busy               = 1'b0;
    assign unused_clear_value = ^CLEAR_VALUE;
`endif

    // Round-robin grant: a lone requester wins, contention goes to the priority pointer
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 1'b0;
        grant_addr  = req0_addr;
        grant_data  = req0_data;
        if (state == RUN) begin
            if (req0_valid && req1_valid) begin
                grant_valid = 1'b1;
                grant_idx   = prio;
            end else if (req0_valid) begin
                grant_valid = 1'b1;
                grant_idx   = 1'b0;
            end else if (req1_valid) begin
                grant_valid = 1'b1;
                grant_idx   = 1'b1;
            end
        end
        if (grant_idx) begin
            grant_addr = req1_addr;
            grant_data = req1_data;
        end
    end

    assign req0_ready = grant_valid && !grant_idx;
    assign req1_ready = grant_valid && grant_idx;

    // Registered write port: sweep writes or the granted request, and the priority flip after a grant
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wrdata <= '0;
            prio       <= 1'b0;
        end else begin
            ram_we <= 1'b0;
`ifdef RAM_ARB_CLEAR_EN
            if (state == CLEAR) begin
                ram_we     <= 1'b1;
                ram_addr   <= clear_cnt;
                ram_wrdata <= CLEAR_VALUE;
            end else
`endif
            if (grant_valid) begin
                ram_we     <= 1'b1;
                ram_addr   <= grant_addr;
                ram_wrdata <= grant_data;
                prio       <= ~grant_idx;
            end
        end
    end

endmodule

// File: tb/tb_ram_write_arbiter.sv
`timescale 1ns/1ps
// tb_ram_write_arbiter: directed stimulus with a scoreboard of expected RAM writes.
// Builds with or without RAM_ARB_CLEAR_EN; the sweep scenarios run only when it is defined.
module tb_ram_write_arbiter;

    localparam int AW = 3;
    localparam int DW = 32;
    localparam logic [DW-1:0] CLEAR_VAL = 32'hDEADBEEF;

`ifdef RAM_ARB_CLEAR_EN
    localparam logic CLEAR_BUILT = 1'b1;
`else
    localparam logic CLEAR_BUILT = 1'b0;
`endif

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          req0_valid = 1'b0;
    logic          req0_ready;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_data = '0;
    logic          req1_valid = 1'b0;
    logic          req1_ready;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_data = '0;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_wrdata;
    logic          busy;

    wr_t           exp_q[$];
    wr_t           mon_item;
    logic [DW-1:0] tb_mem [0:7];
    int            checks = 0;
    int            errors = 0;

    ram_write_arbiter #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CLEAR_VALUE(CLEAR_VAL)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wrdata (ram_wrdata),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // A stalled writer must keep its request up and unchanged until accepted
    property hold0;
        @(posedge clk) disable iff (!rstn)
        (req0_valid && !req0_ready) |=> (req0_valid && $stable(req0_addr) && $stable(req0_data));
    endproperty
    property hold1;
        @(posedge clk) disable iff (!rstn)
        (req1_valid && !req1_ready) |=> (req1_valid && $stable(req1_addr) && $stable(req1_data));
    endproperty
    assert property (hold0) else $error("[TB] writer 0 dropped or changed a stalled request");
    assert property (hold1) else $error("[TB] writer 1 dropped or changed a stalled request");

    task automatic checkOutput(input string name, input logic [DW-1:0] actual, input logic [DW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic checkReady(input logic exp0, input logic exp1);
        checkOutput("req0_ready", {31'd0, req0_ready}, {31'd0, exp0});
        checkOutput("req1_ready", {31'd0, req1_ready}, {31'd0, exp1});
    endtask

    task automatic pushWrite(input logic [AW-1:0] addr, input logic [DW-1:0] data);
        wr_t w;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic nextCycle();
        @(negedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                                 input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0_valid = v0;
        req0_addr  = a0;
        req0_data  = d0;
        req1_valid = v1;
        req1_addr  = a1;
        req1_data  = d1;
        #1;
    endtask

`ifdef RAM_ARB_CLEAR_EN
    // First sweep cycle is the current one; writers must be held off throughout
    task automatic runSweep(input int n);
        for (int c = 0; c < n; c++) begin
            if (c != 0) nextCycle();
            checkOutput("sweep_busy", {31'd0, busy}, 32'd1);
            checkReady(1'b0, 1'b0);
            pushWrite(AW'(c), CLEAR_VAL);
        end
    endtask
`endif

    // Monitor: every RAM write must match the oldest expected write, in order
    always @(negedge clk) begin
`ifndef RAM_ARB_CLEAR_EN
        checkOutput("busy_tied_low", {31'd0, busy}, 32'd0);
`endif
        if (ram_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", ram_addr, ram_wrdata);
            end else begin
                mon_item = exp_q.pop_front();
                checkOutput("ram_addr", {29'd0, ram_addr}, {29'd0, mon_item.addr});
                checkOutput("ram_wrdata", ram_wrdata, mon_item.data);
            end
            tb_mem[ram_addr] = ram_wrdata;
        end
    end

    // Watchdog so a stuck run still ends with a report
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;
        int i0;
        int i1;

        repeat (3) nextCycle();
        checkOutput("reset_we", {31'd0, ram_we}, 32'd0);
        checkOutput("reset_addr", {29'd0, ram_addr}, 32'd0);
        checkOutput("reset_data", ram_wrdata, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, {31'd0, CLEAR_BUILT});
        checkReady(1'b0, 1'b0);

`ifdef RAM_ARB_CLEAR_EN
        // Partial sweep interrupted by reset at address 3, both writers waiting
        nextCycle();
        rstn = 1'b1;
        applyStimulus(1'b1, 3'd1, 32'h11, 1'b1, 3'd2, 32'h22);
        runSweep(4);
        nextCycle();
        rstn = 1'b0;
        #1;
        checkOutput("midsweep_reset_we", {31'd0, ram_we}, 32'd0);
        checkOutput("midsweep_reset_busy", {31'd0, busy}, 32'd1);
        nextCycle();
        checkOutput("midsweep_reset_we2", {31'd0, ram_we}, 32'd0);
        checkOutput("midsweep_reset_busy2", {31'd0, busy}, 32'd1);

        // Full sweep after release, then the first writer is taken
        nextCycle();
        rstn = 1'b1;
        #1;
        runSweep(8);
        nextCycle();
        checkOutput("sweep_done_busy", {31'd0, busy}, 32'd0);
        checkReady(1'b1, 1'b0);
        pushWrite(3'd1, 32'h11);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 3'd2, 32'h22);
        checkReady(1'b0, 1'b1);
        pushWrite(3'd2, 32'h22);
`else
        // Writer accepted in the very first cycle after release
        nextCycle();
        rstn = 1'b1;
        applyStimulus(1'b1, 3'd2, 32'h55, 1'b0, 3'd0, 32'h0);
        checkReady(1'b1, 1'b0);
        checkOutput("first_cycle_busy", {31'd0, busy}, 32'd0);
        pushWrite(3'd2, 32'h55);
`endif

        // Writer 1 alone for three cycles
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, AW'(5 + k), DW'(1 + k));
            checkReady(1'b0, 1'b1);
            pushWrite(AW'(5 + k), DW'(1 + k));
        end
        nextCycle();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
        checkReady(1'b0, 1'b0);
        nextCycle();
        checkOutput("idle_we", {31'd0, ram_we}, 32'd0);
        checkOutput("idle_hold_addr", {29'd0, ram_addr}, 32'd7);
        checkOutput("idle_hold_data", ram_wrdata, 32'd3);

        // Both writers continuously valid: grants alternate starting with writer 0
        for (int c = 0; c < 8; c++) begin
            i0 = (c + 1) / 2;
            i1 = c / 2;
            a0 = AW'(i0);
            d0 = (i0 == 4) ? 32'hAA : 32'h100 + DW'(i0);
            a1 = AW'(7 - i1);
            d1 = 32'h200 + DW'(i1);
            nextCycle();
            applyStimulus(1'b1, a0, d0, 1'b1, a1, d1);
            checkReady(c % 2 == 0, c % 2 == 1);
            if (c % 2 == 0) pushWrite(a0, d0);
            else            pushWrite(a1, d1);
        end

        // Same-address collision: 0xAA lands first, 0xBB persists
        nextCycle();
        applyStimulus(1'b1, 3'd4, 32'hAA, 1'b1, 3'd4, 32'hBB);
        checkReady(1'b1, 1'b0);
        pushWrite(3'd4, 32'hAA);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 3'd4, 32'hBB);
        checkReady(1'b0, 1'b1);
        pushWrite(3'd4, 32'hBB);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
        nextCycle();
        checkOutput("collision_readback", tb_mem[4], 32'hBB);

        // Reset while a write is registered; priority must return to writer 0
        applyStimulus(1'b1, 3'd3, 32'h77, 1'b0, 3'd0, 32'h0);
        checkReady(1'b1, 1'b0);
        pushWrite(3'd3, 32'h77);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);
        rstn = 1'b0;
        #1;
        checkOutput("traffic_reset_we", {31'd0, ram_we}, 32'd0);
        checkOutput("traffic_reset_addr", {29'd0, ram_addr}, 32'd0);
        checkOutput("traffic_reset_data", ram_wrdata, 32'd0);
        checkOutput("traffic_reset_busy", {31'd0, busy}, {31'd0, CLEAR_BUILT});
        nextCycle();
        nextCycle();
        rstn = 1'b1;
        applyStimulus(1'b1, 3'd5, 32'h5A, 1'b1, 3'd6, 32'hA5);
`ifdef RAM_ARB_CLEAR_EN
        runSweep(8);
        nextCycle();
`endif
        checkReady(1'b1, 1'b0);
        pushWrite(3'd5, 32'h5A);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b1, 3'd6, 32'hA5);
        checkReady(1'b0, 1'b1);
        pushWrite(3'd6, 32'hA5);
        nextCycle();
        applyStimulus(1'b0, 3'd0, 32'h0, 1'b0, 3'd0, 32'h0);

        // Every expected write must have been seen
        repeat (3) nextCycle();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("[TB] FAIL drain: got %0d writes outstanding, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_write_arbiter.md
Name: ram_write_arbiter

Overview:
- Shares the single write port (addr/we/wrdata) of a simple dual-port RAM between two independent writers, using valid/ready handshakes and round-robin arbitration.
- Optionally sweeps the whole RAM to a known value after reset before accepting any writer.
- Sits directly in front of the RAM write port; the RAM read port is untouched.

Parameters:
- ADDR_WIDTH, 16, RAM address width; RAM depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 64, RAM word width.
- CLEAR_VALUE, 0, DATA_WIDTH-bit word written to every address during the clear sweep.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rstn  input  1  asynchronous active-low reset.
- req0_valid  input  1  writer 0 has a pending write.
- req0_ready  output  1  writer 0 write accepted this cycle.
- req0_addr  input  ADDR_WIDTH  writer 0 target address.
- req0_data  input  DATA_WIDTH  writer 0 write data.
- req1_valid / req1_ready / req1_addr / req1_data  same as writer 0, for writer 1.
- ram_addr  output  ADDR_WIDTH  to RAM write address.
- ram_we  output  1  to RAM write enable.
- ram_wrdata  output  DATA_WIDTH  to RAM write data.
- busy  output  1  high while the clear sweep runs.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rstn.
- Reset values:
  - ram_we=0, ram_addr=0, ram_wrdata=0.
  - busy=1 with RAM_ARB_CLEAR_EN, else 0.
  - Priority pointer prio=0; clear counter=0.
  - FSM state=CLEAR with RAM_ARB_CLEAR_EN, else RUN.
- FSM states: CLEAR and RUN. RUN is terminal until the next reset.
- CLEAR state:
  - Each cycle, registers ram_we=1, ram_addr=counter, ram_wrdata=CLEAR_VALUE; counter increments.
  - req0_ready=req1_ready=0 regardless of valid; busy=1.
  - When counter == 2**ADDR_WIDTH-1, the transition to RUN occurs on that edge and the counter must not wrap into a second pass.
  - busy drops in the same cycle that ram_we shows the last clear address.
  - Exactly 2**ADDR_WIDTH clear writes, addresses 0..depth-1 in ascending order.
- RUN state, grant (combinational):
  - Only reqN_valid → grant N.
  - Both valid → grant prio.
  - Neither valid → no grant.
- RUN state, ready:
  - reqN_ready = (state==RUN) && grant==N.
  - ready may depend combinationally on valid; writers must not make valid depend on ready.
- Transfer: valid && ready at a clock edge.
- On a transfer from writer N:
  - prio <= 1-N, so fairness alternates under contention.
  - The next cycle shows ram_we=1, ram_addr=reqN_addr, ram_wrdata=reqN_data.
  - Latency is exactly one cycle from handshake to RAM write.
- Cycle with no transfer: ram_we=0 next cycle; ram_addr and ram_wrdata hold their last values.
- Throughput: one write per cycle sustained; at most one transfer per cycle in total.
- Writer rules: while valid && !ready, a writer holds addr/data stable and keeps valid high. Dropping valid without a handshake is illegal; the bench flags it with an assertion.
- Both writers targeting the same address: the RAM receives the writes in grant order, so the later grant's data persists.
- Reset asserted mid-sweep or mid-traffic:
  - All state returns to reset values immediately (asynchronous).
  - The sweep restarts from address 0 after rstn deasserts.
  - An in-flight registered write is dropped: ram_we=0 during reset.

Optional Feature:
- Macro: RAM_ARB_CLEAR_EN.
- Defined: the CLEAR state and counter are built; the post-reset sweep is as above; busy is functional.
- Undefined: the CLEAR state and counter are not built; the FSM resets to RUN; busy is tied 0; writers may be accepted in the first cycle after reset release.

Test Plan:
1. RAM_ARB_CLEAR_EN, ADDR_WIDTH=3, CLEAR_VALUE=32'hDEADBEEF, release rstn, both writers valid → ram_we=1 for 8 consecutive cycles with addr 0..7, data DEADBEEF; ready=0 throughout; busy falls with addr 7; first writer accepted the next cycle; no 9th clear write.
2. RUN, only writer 1 valid for 3 cycles (addr 5,6,7; data 1,2,3) → req1_ready=1 each cycle; ram_we/addr/data show (5,1),(6,2),(7,3) one cycle later; req0_ready stays 0.
3. RUN, both writers continuously valid, prio=0 → grants alternate 0,1,0,1; each writer gets exactly 4 writes in 8 cycles; ram_we=1 every cycle.
4. Both writers valid to addr 4, writer 0 data 0xAA, writer 1 data 0xBB, prio=0 → RAM receives 0xAA then 0xBB on consecutive cycles; a read of addr 4 afterwards returns 0xBB. Writer 1 holds stable during its 1-cycle stall.
5. Assert rstn low at clear address 3 for 2 cycles, then release → ram_we=0 and busy=1 during reset; the sweep restarts at address 0 and completes all 8 addresses.
6. Macro undefined, release rstn with writer 0 valid (addr 2, data 0x55) → req0_ready=1 in the first cycle; busy=0 throughout; ram write (2, 0x55) appears next cycle.
